// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Odd parity: data plus parity bit always holds an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, stability filter and a one-cycle
// pulse on each accepted high-to-low transition.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk_vga,
  input  logic reset_btn,
  input  logic pin,
  output logic sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // Idle PS/2 lines are pulled high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      level      <= 1'b1;
      stable_cnt <= '0;
      fall       <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      fall    <= 1'b0;
      if (sync_p1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILTER_CYCLES - 1)) begin
        level      <= sync_p1;
        stable_cnt <= '0;
        fall       <= level;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign sync = sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, ACK check, and a done/error pulse on completion.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       rx_mask,
  output logic       done,
  output logic       error
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t     state;
  logic          clk_sync;
  logic          clk_fall;
  logic          data_p0;
  logic          data_p1;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    frame;
  logic          nack;
  logic [9:0]    wire_bits;
  logic          timed_out;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk_vga  (clk_vga),
    .reset_btn(reset_btn),
    .pin      (ps2_clock_in),
    .sync     (clk_sync),
    .fall     (clk_fall)
  );

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= ps2_data_in;
      data_p1 <= data_p0;
    end
  end

  // Payload holds no control meaning, so it is loaded without reset.
  always_ff @(posedge clk_vga) begin
    if (state == IDLE && tx_valid)
      frame <= {odd_parity(tx_data), tx_data};
  end

  // Stop bit is 1, so driving ~bit on it releases the data line.
  assign wire_bits = {1'b1, frame};
  assign timed_out = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      tmo_cnt      <= '0;
      bit_idx      <= '0;
      nack         <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state        <= INHIBIT;
            ps2_clock_oe <= 1'b1;
            ps2_data_oe  <= 1'b0;
            phase_cnt    <= '0;
          end
        end
        INHIBIT: begin
          if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
            state       <= RTS;
            ps2_data_oe <= 1'b1;
            phase_cnt   <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        RTS: begin
          if (phase_cnt == PW'(SETUP_CYCLES - 1)) begin
            state        <= SEND;
            ps2_clock_oe <= 1'b0;
            bit_idx      <= '0;
            tmo_cnt      <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SEND: begin
          if (clk_fall) begin
            tmo_cnt     <= '0;
            ps2_data_oe <= ~wire_bits[bit_idx];
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == 4'd9)
              state <= ACK;
          end else if (timed_out) begin
            state       <= IDLE;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ACK: begin
          if (clk_fall) begin
            nack    <= data_p1;
            tmo_cnt <= '0;
            state   <= WAIT_IDLE;
          end else if (timed_out) begin
            state <= IDLE;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_p1) begin
            done  <= ~nack;
            error <= nack;
            state <= IDLE;
          end else if (timed_out) begin
            state <= IDLE;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign rx_mask  = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines,
// randomised command bytes and a frame-level reference model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 40;
  localparam int SET   = 6;
  localparam int FIL   = 3;
  localparam int TMO   = 400;
  localparam int HALF  = 12;
  localparam int LIMIT = 2000;

  logic       clk_vga = 1'b0;
  logic       reset_btn = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       rx_mask;
  logic       done;
  logic       error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .FILTER_CYCLES (FIL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_vga     (clk_vga),
    .reset_btn   (reset_btn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_mask     (rx_mask),
    .done        (done),
    .error       (error)
  );

  always #5 clk_vga = ~clk_vga;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  // Line monitor: phase lengths, frame count and pulse bookkeeping.
  int   cyc = 0;
  int   run_i = 0, run_s = 0, inhib_len = 0, setup_len = 0, frames = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, skew_cnt = 0;
  int   send_cyc = 0, err_cyc = 0;
  logic prev_coe = 1'b0;

  always @(posedge clk_vga) cyc <= cyc + 1;

  always @(negedge clk_vga) begin
    prev_coe <= ps2_clock_oe;
    if (ps2_clock_oe && !ps2_data_oe) run_i <= run_i + 1;
    if (ps2_clock_oe && ps2_data_oe)  run_s <= run_s + 1;
    if (prev_coe && !ps2_clock_oe) begin
      inhib_len <= run_i;
      setup_len <= run_s;
      run_i     <= 0;
      run_s     <= 0;
      send_cyc  <= cyc;
      frames    <= frames + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && error) both_cnt <= both_cnt + 1;
    if ((done || error) && !tx_ready) skew_cnt <= skew_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the ten device-visible bits, LSB first, odd parity, stop high.
  function automatic logic [9:0] wire_model(input logic [7:0] b);
    logic [9:0] w;
    int v;
    v = int'(b);
    for (int i = 0; i < 8; i++) w[i] = ((v >> i) & 1) == 1;
    w[8] = ($countones(b) % 2) == 0;
    w[9] = 1'b1;
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input string tag);
    @(negedge clk_vga);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk_vga);
    tx_valid = 1'b0;
    check_val({tag, ".accept"}, {29'd0, tx_ready, ps2_clock_oe, rx_mask}, 32'd3);
  endtask

  // Device: waits for request-to-send, then clocks npulses; pulse 11 carries the ACK.
  task automatic device(input bit ack, input int npulses, output logic [9:0] bits, output bit started);
    int n;
    bits    = '0;
    started = 1'b0;
    n       = 0;
    while (!(ps2_clock_in === 1'b1 && ps2_data_in === 1'b0) && n < LIMIT) begin
      @(negedge clk_vga);
      n++;
    end
    if (n >= LIMIT) return;
    started = 1'b1;
    repeat (20) @(negedge clk_vga);
    for (int i = 0; i < npulses; i++) begin
      if (i == 10 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_vga);
      if (i < 10) bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk_vga);
      if (i == 10) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < LIMIT) begin
      @(negedge clk_vga);
      n++;
    end
    check_val({tag, ".ready"}, {31'd0, tx_ready}, 32'd1);
    @(negedge clk_vga);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input string tag);
    int         d0, e0;
    logic [9:0] bits;
    bit         st;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b, tag);
    device(ack, 11, bits, st);
    wait_ready(tag);
    check_val({tag, ".bits"}, {22'd0, bits}, {22'd0, wire_model(b)});
    check_val({tag, ".done"}, done_cnt - d0, {31'd0, ack});
    check_val({tag, ".error"}, err_cnt - e0, {31'd0, !ack});
  endtask

  initial begin
    logic [9:0] bits;
    bit         st;
    int         d0, e0, f0;
    logic [7:0] rb;
    bit         rack;

    repeat (3) @(negedge clk_vga);
    check_val("rst.outputs", {26'd0, tx_ready, ps2_clock_oe, ps2_data_oe, rx_mask, done, error},
              32'b100000);
    reset_btn = 1'b0;
    repeat (3) @(negedge clk_vga);

    run_frame(PS2_CMD_SET_LEDS, 1'b1, "t1_ed");
    check_val("t1_inhibit_len", inhib_len, INH);
    check_val("t1_setup_len", setup_len, SET);

    run_frame(8'h00, 1'b1, "t2_00");
    run_frame(8'h01, 1'b1, "t2_01");

    // Device never clocks: the host must give up on its own.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hA5, "t3");
    device(1'b1, 0, bits, st);
    check_val("t3_rts_seen", {31'd0, st}, 32'd1);
    wait_ready("t3");
    check_val("t3_error", err_cnt - e0, 1);
    check_val("t3_done", done_cnt - d0, 0);
    check_val("t3_latency", err_cyc - send_cyc, TMO);
    check_val("t3_lines", {30'd0, ps2_clock_oe, ps2_data_oe}, 0);

    run_frame(8'h3C, 1'b0, "t4_nack");

    // tx_valid held through a busy frame: only the first byte goes out.
    d0 = done_cnt;
    f0 = frames;
    @(negedge clk_vga);
    tx_valid = 1'b1;
    tx_data  = PS2_CMD_SET_LEDS;
    @(negedge clk_vga);
    tx_data  = 8'h55;
    check_val("t5_busy", {31'd0, tx_ready}, 0);
    device(1'b1, 11, bits, st);
    check_val("t5_first_bits", {22'd0, bits}, {22'd0, wire_model(PS2_CMD_SET_LEDS)});
    for (int n = 0; n < LIMIT && !tx_ready; n++) @(negedge clk_vga);
    @(negedge clk_vga);
    check_val("t5_reaccept", {31'd0, tx_ready}, 0);
    check_val("t5_frames", frames - f0, 1);
    check_val("t5_first_done", done_cnt - d0, 1);
    tx_valid = 1'b0;
    device(1'b1, 11, bits, st);
    wait_ready("t5b");
    check_val("t5_second_bits", {22'd0, bits}, {22'd0, wire_model(8'h55)});
    check_val("t5_second_done", done_cnt - d0, 2);

    // Reset in the middle of the data bits.
    send_byte(8'h00, "t6");
    device(1'b1, 4, bits, st);
    @(negedge clk_vga);
    check_val("t6_driving", {31'd0, ps2_data_oe}, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 reset_btn = 1'b1;
    #1 check_val("t6_reset", {28'd0, ps2_clock_oe, ps2_data_oe, tx_ready, rx_mask}, 32'b0010);
    repeat (3) @(negedge clk_vga);
    reset_btn = 1'b0;
    repeat (20) @(negedge clk_vga);
    check_val("t6_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    run_frame(PS2_CMD_RESET, 1'b1, "t6_ff");

    for (int k = 0; k < 8; k++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_frame(rb, rack, $sformatf("rnd%0d", k));
    end

    check_val("pulse_overlap", both_cnt, 0);
    check_val("pulse_vs_ready", skew_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
